// File: rtl/shift_unit_pipe.sv
// Pipelined multi-mode barrel shifter (SHL/SHR/SHRA/ROL/ROR/PASS) with valid/ready flow control.
// The shift levels are spread over PIPE_DEPTH register banks, with the LSB levels first.
module shift_unit_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Z,
  output logic                  zero
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned GRP = (SHW + PIPE_DEPTH - 1) / PIPE_DEPTH;

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  // First level of stage s. Groups are GRP wide, but each later stage is still left at least one level.
  function automatic int unsigned lvl_lo(input int unsigned s);
    int unsigned a;
    int unsigned b;
    a = s * GRP;
    b = SHW - PIPE_DEPTH + s;
    return (a < b) ? a : b;
  endfunction

  // One mux level: shift or rotate by 2^k. SHRA fills with the sign of the original operand.
  function automatic logic [W-1:0] shift_lvl(input logic [W-1:0] x, input int unsigned k,
                                             input logic [2:0] o, input logic sg);
    int unsigned  amt;
    logic [W-1:0] fill;
    amt  = 32'd1 << k;
    fill = {W{sg}} << (W - amt);
    case (o)
      OP_SHL:  return x << amt;
      OP_SHR:  return x >> amt;
      OP_SHRA: return (x >> amt) | fill;
      OP_ROL:  return (x << amt) | (x >> (W - amt));
      OP_ROR:  return (x >> amt) | (x << (W - amt));
      default: return x;
    endcase
  endfunction

  logic [PIPE_DEPTH-1:0] vbits;
  logic [PIPE_DEPTH-1:0] ld;

  // A stage loads if it or any stage downstream of it is empty, or if the consumer takes the result.
  always_comb begin
    ld = '0;
    ld[PIPE_DEPTH-1] = !vbits[PIPE_DEPTH-1] || out_ready;
    for (int s = int'(PIPE_DEPTH) - 2; s >= 0; s--) begin
      ld[s] = !vbits[s] || ld[s+1];
    end
  end

  assign in_ready = ld[0];

  for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
    localparam int unsigned LO = lvl_lo(s);
    localparam int unsigned HI = lvl_lo(s + 1);

    logic           v_in;
    logic [W-1:0]   d_in;
    logic [SHW-1:0] sh_in;
    logic [2:0]     op_in;
    logic           sg_in;
    logic [W-1:0]   d_nx;
    logic [W-1:0]   chain [HI-LO+1];

    logic           v_q;
    logic [W-1:0]   d_q;
    logic [SHW-1:0] sh_q;
    logic [2:0]     op_q;
    logic           sg_q;
    logic           unused_sh;

    if (s == 0) begin : g_head
      logic unused_b;
      assign v_in     = in_valid;
      assign d_in     = A;
      assign sh_in    = B[SHW-1:0];
      assign op_in    = op;
      assign sg_in    = A[W-1];
      assign unused_b = ^B[W-1:SHW];
    end else begin : g_body
      assign v_in  = g_stage[s-1].v_q;
      assign d_in  = g_stage[s-1].d_q;
      assign sh_in = g_stage[s-1].sh_q;
      assign op_in = g_stage[s-1].op_q;
      assign sg_in = g_stage[s-1].sg_q;
    end

    // Only bits LO..HI-1 of the count are consumed here; earlier bits were used upstream.
    assign unused_sh = ^sh_in;

    assign chain[0] = d_in;
    for (genvar k = LO; k < HI; k++) begin : g_lvl
      assign chain[k-LO+1] = sh_in[k] ? shift_lvl(chain[k-LO], k, op_in, sg_in) : chain[k-LO];
    end
    assign d_nx = chain[HI-LO];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q  <= 1'b0;
        d_q  <= '0;
        sh_q <= '0;
        op_q <= '0;
        sg_q <= 1'b0;
      end else if (ld[s]) begin
        v_q <= v_in;
        if (v_in) begin
          d_q  <= d_nx;
          sh_q <= sh_in;
          op_q <= op_in;
          sg_q <= sg_in;
        end
      end
    end

    assign vbits[s] = v_q;

    if (s == PIPE_DEPTH - 1) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^{sh_q, op_q, sg_q};
    end
  end

  // zero is computed from the final-stage result and cleared when a bubble moves into the output bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero <= 1'b0;
    end else if (ld[PIPE_DEPTH-1]) begin
      zero <= g_stage[PIPE_DEPTH-1].v_in && (g_stage[PIPE_DEPTH-1].d_nx == '0);
    end
  end

  assign out_valid = g_stage[PIPE_DEPTH-1].v_q;
  assign Z         = g_stage[PIPE_DEPTH-1].d_q;

endmodule
